// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl - multicycle sequencer for the shared ALU datapath.
//
// Each instruction walks fetch / decode / execute / memory / write-back.
// Outputs are decoded combinationally from the registered state, plus
// mem_ready and zero. They are held at 0 for as long as reset is low.
// Because of this, an abandoned instruction never leaks a partial strobe.
//
// Optional feature macro: ULA_SEQ_INC_EN
//   defined   : opcode 0x3F runs INC (rt <- rs + 1, B source = constant 1)
//   undefined : opcode 0x3F is illegal, and B-select code 011 is never driven
//
// state    | code | meaning
// ---------+------+-----------------------------------------------------
// FETCH    |  0   | read instruction at PC, PC <- PC + 4 on mem_ready
// DECODE   |  1   | ALUOut <- PC + (imm << 2), pick instruction class
// EXEC_R   |  2   | ALUOut <- A op B, op taken from funct
// EXEC_I   |  3   | ALUOut <- A + sign-extended imm
// MEM_ADDR |  4   | ALUOut <- A + sign-extended imm (effective address)
// MEM_RD   |  5   | load from ALUOut, wait on mem_ready
// MEM_WR   |  6   | store to ALUOut, wait on mem_ready
// WB_R     |  7   | rd <- ALUOut
// WB_I     |  8   | rt <- ALUOut
// WB_MEM   |  9   | rt <- MDR
// BRANCH   | 10   | compare A - B, PC <- ALUOut when zero
// JUMP     | 11   | PC <- jump target
// INC      | 12   | ALUOut <- A + 1 (only with ULA_SEQ_INC_EN)
// ILLEGAL  | 15   | undecodable instruction, parked until reset

module ula_seq_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ula_a_sel,
    output logic [2:0] ula_b_sel,
    output logic [2:0] ula_op,
    output logic       pc_write,
    output logic       ir_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_INC      = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [2:0] B_REG   = 3'b000;
    localparam logic [2:0] B_EXT   = 3'b001;
    localparam logic [2:0] B_FOUR  = 3'b010;
    localparam logic [2:0] B_ONE   = 3'b011;
    localparam logic [2:0] B_SHIFT = 3'b100;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_INC   = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    state_t state;
    state_t state_nxt;

    // Ungated decode of the current state. These are zeroed below while reset is low.
    logic       a_sel_c;
    logic [2:0] b_sel_c;
    logic [2:0] op_c;
    logic       pc_write_c;
    logic       ir_write_c;
    logic       aluout_write_c;
    logic       reg_write_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       i_or_d_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic [1:0] pc_src_c;
    logic       illegal_c;

    // True when funct names one of the supported R-type operations.
    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    // ALU operation for an R-type funct field. Unknown codes fall back to pass-A.
    function automatic logic [2:0] funct_op(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return OP_ADD;
            FN_SUB:  return OP_SUB;
            FN_AND:  return OP_AND;
            FN_OR:   return OP_OR;
            FN_SLT:  return OP_SLT;
            default: return OP_PASS;
        endcase
    endfunction

    // Instruction-class dispatch out of DECODE.
    function automatic state_t decode_target(input logic [5:0] opc, input logic [5:0] fn);
        case (opc)
            OPC_RTYPE: return funct_ok(fn) ? S_EXEC_R : S_ILLEGAL;
            OPC_ADDI:  return S_EXEC_I;
            OPC_LW,
            OPC_SW:    return S_MEM_ADDR;
            OPC_BEQ:   return S_BRANCH;
            OPC_J:     return S_JUMP;
`ifdef ULA_SEQ_INC_EN
            OPC_INC:   return S_INC;
`endif
            default:   return S_ILLEGAL;
        endcase
    endfunction

    // State register. Reset returns to FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_nxt      = state;
        a_sel_c        = 1'b0;
        b_sel_c        = B_REG;
        op_c           = OP_PASS;
        pc_write_c     = 1'b0;
        ir_write_c     = 1'b0;
        aluout_write_c = 1'b0;
        reg_write_c    = 1'b0;
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        i_or_d_c       = 1'b0;
        reg_dst_c      = 1'b0;
        mem_to_reg_c   = 1'b0;
        pc_src_c       = 2'b00;
        illegal_c      = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read_c = 1'b1;
                b_sel_c    = B_FOUR;
                op_c       = OP_ADD;
                // IR and PC are written only on the completing cycle of the fetch.
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                b_sel_c        = B_SHIFT;
                op_c           = OP_ADD;
                aluout_write_c = 1'b1;
                state_nxt      = decode_target(opcode, funct);
            end
            S_EXEC_R: begin
                a_sel_c        = 1'b1;
                b_sel_c        = B_REG;
                op_c           = funct_op(funct);
                aluout_write_c = 1'b1;
                state_nxt      = S_WB_R;
            end
            S_EXEC_I: begin
                a_sel_c        = 1'b1;
                b_sel_c        = B_EXT;
                op_c           = OP_ADD;
                aluout_write_c = 1'b1;
                state_nxt      = S_WB_I;
            end
`ifdef ULA_SEQ_INC_EN
            S_INC: begin
                a_sel_c        = 1'b1;
                b_sel_c        = B_ONE;
                op_c           = OP_ADD;
                aluout_write_c = 1'b1;
                state_nxt      = S_WB_I;
            end
`endif
            S_MEM_ADDR: begin
                a_sel_c        = 1'b1;
                b_sel_c        = B_EXT;
                op_c           = OP_ADD;
                aluout_write_c = 1'b1;
                // Only lw/sw dispatch here. Anything else means IR changed underneath us.
                if (opcode == OPC_LW) begin
                    state_nxt = S_MEM_RD;
                end else if (opcode == OPC_SW) begin
                    state_nxt = S_MEM_WR;
                end else begin
                    state_nxt = S_ILLEGAL;
                end
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_FETCH;
                end
            end
            S_WB_R: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_WB_I: begin
                reg_write_c = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BRANCH: begin
                a_sel_c    = 1'b1;
                b_sel_c    = B_REG;
                op_c       = OP_SUB;
                pc_src_c   = 2'b01;
                pc_write_c = zero;
                state_nxt  = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                pc_src_c   = 2'b10;
                state_nxt  = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                state_nxt = S_ILLEGAL;
            end
            default: begin
                // Unused encodings, including INC when the feature is off, trap as illegal.
                state_nxt = S_ILLEGAL;
            end
        endcase
    end

    // Hold every output at 0 while reset is low. In-flight strobes drop in the same cycle.
    always_comb begin
        ula_a_sel    = 1'b0;
        ula_b_sel    = B_REG;
        ula_op       = OP_PASS;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        pc_src       = 2'b00;
        illegal      = 1'b0;
        state_dbg    = 4'd0;
        if (reset) begin
            ula_a_sel    = a_sel_c;
            ula_b_sel    = b_sel_c;
            ula_op       = op_c;
            pc_write     = pc_write_c;
            ir_write     = ir_write_c;
            aluout_write = aluout_write_c;
            reg_write    = reg_write_c;
            mem_read     = mem_read_c;
            mem_write    = mem_write_c;
            i_or_d       = i_or_d_c;
            reg_dst      = reg_dst_c;
            mem_to_reg   = mem_to_reg_c;
            pc_src       = pc_src_c;
            illegal      = illegal_c;
            state_dbg    = state;
        end
    end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed bench for ula_seq_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well clear of the rising edge.
// Define ULA_SEQ_INC_EN here as well when building the INC variant.

module tb_ula_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       ula_a_sel;
    logic [2:0] ula_b_sel;
    logic [2:0] ula_op;
    logic       pc_write, ir_write, aluout_write, reg_write, mem_read, mem_write;
    logic       i_or_d, reg_dst, mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
    logic [3:0] state_dbg;

    int n_chk = 0;
    int n_err = 0;
    int wr_cnt;

    ula_seq_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .ula_a_sel    (ula_a_sel),
        .ula_b_sel    (ula_b_sel),
        .ula_op       (ula_op),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .aluout_write (aluout_write),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .i_or_d       (i_or_d),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .pc_src       (pc_src),
        .illegal      (illegal),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    wire [22:0] all_outs = {ula_a_sel, ula_b_sel, ula_op, pc_write, ir_write, aluout_write,
                            reg_write, mem_read, mem_write, i_or_d, reg_dst, mem_to_reg,
                            pc_src, illegal, state_dbg};
    wire [5:0]  strobes  = {pc_write, ir_write, aluout_write, reg_write, mem_read, mem_write};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge, apply inputs, and let the combinational outputs settle.
    task automatic nxt(input logic mr, input logic z);
        @(negedge clk);
        mem_ready = mr;
        zero      = z;
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h20;
        zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset held low for three cycles: every output must be 0.
        for (int i = 0; i < 3; i++) begin
            nxt(1'b1, 1'b0);
            chk("rst_all_zero", all_outs, 23'd0);
        end

        // Release. The first cycle is FETCH with the strobes already active.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("f_state", state_dbg, 4'd0);
        chk("f_bsel", ula_b_sel, 3'b010);
        chk("f_pcw", pc_write, 1'b1);
        chk("f_irw", ir_write, 1'b1);
        chk("f_op", ula_op, 3'b001);
        chk("f_memrd", mem_read, 1'b1);

        // R-type add: states 0,1,2,7,0.
        nxt(1'b1, 1'b0);
        chk("r_s1", state_dbg, 4'd1);
        chk("r_b1", ula_b_sel, 3'b100);
        chk("r_aluw1", aluout_write, 1'b1);
        nxt(1'b1, 1'b0);
        chk("r_s2", state_dbg, 4'd2);
        chk("r_b2", ula_b_sel, 3'b000);
        chk("r_op2", ula_op, 3'b001);
        chk("r_a2", ula_a_sel, 1'b1);
        nxt(1'b1, 1'b0);
        chk("r_s7", state_dbg, 4'd7);
        chk("r_b7", ula_b_sel, 3'b000);
        chk("r_wr7", {reg_write, reg_dst, mem_to_reg}, 3'b110);
        nxt(1'b1, 1'b0);
        chk("r_s0", state_dbg, 4'd0);

        // lw with mem_ready low for two cycles in MEM_RD: 7 cycles total.
        opcode = 6'h23;
        wr_cnt = int'(reg_write);
        nxt(1'b1, 1'b0);
        chk("lw_s1", state_dbg, 4'd1);
        wr_cnt += int'(reg_write);
        nxt(1'b1, 1'b0);
        chk("lw_s4", state_dbg, 4'd4);
        chk("lw_b4", ula_b_sel, 3'b001);
        wr_cnt += int'(reg_write);
        nxt(1'b0, 1'b0);
        chk("lw_s5a", state_dbg, 4'd5);
        chk("lw_rd5", {mem_read, mem_write, i_or_d}, 3'b101);
        wr_cnt += int'(reg_write);
        nxt(1'b0, 1'b0);
        chk("lw_s5b", state_dbg, 4'd5);
        wr_cnt += int'(reg_write);
        nxt(1'b1, 1'b0);
        chk("lw_s5c", state_dbg, 4'd5);
        wr_cnt += int'(reg_write);
        nxt(1'b1, 1'b0);
        chk("lw_s9", state_dbg, 4'd9);
        chk("lw_wb9", {reg_write, reg_dst, mem_to_reg}, 3'b101);
        wr_cnt += int'(reg_write);
        chk("lw_wr_cnt", wr_cnt, 1);
        nxt(1'b1, 1'b0);
        chk("lw_s0", state_dbg, 4'd0);

        // beq taken.
        opcode = 6'h04;
        nxt(1'b1, 1'b0);
        chk("beq1_s1", state_dbg, 4'd1);
        nxt(1'b1, 1'b1);
        chk("beq1_s10", state_dbg, 4'd10);
        chk("beq1_pc", {pc_write, pc_src}, 3'b101);
        chk("beq1_op", ula_op, 3'b010);
        nxt(1'b1, 1'b0);
        chk("beq1_s0", state_dbg, 4'd0);

        // beq not taken.
        nxt(1'b1, 1'b0);
        chk("beq0_s1", state_dbg, 4'd1);
        nxt(1'b1, 1'b0);
        chk("beq0_s10", state_dbg, 4'd10);
        chk("beq0_pcw", pc_write, 1'b0);
        nxt(1'b1, 1'b0);
        chk("beq0_s0", state_dbg, 4'd0);

        // j
        opcode = 6'h02;
        nxt(1'b1, 1'b0);
        nxt(1'b1, 1'b0);
        chk("j_s11", state_dbg, 4'd11);
        chk("j_pc", {pc_write, pc_src}, 3'b110);
        nxt(1'b1, 1'b0);
        chk("j_s0", state_dbg, 4'd0);

        // addi
        opcode = 6'h08;
        nxt(1'b1, 1'b0);
        nxt(1'b1, 1'b0);
        chk("addi_s3", state_dbg, 4'd3);
        chk("addi_b3", ula_b_sel, 3'b001);
        nxt(1'b1, 1'b0);
        chk("addi_s8", state_dbg, 4'd8);
        chk("addi_wb8", {reg_write, reg_dst, mem_to_reg}, 3'b100);
        nxt(1'b1, 1'b0);
        chk("addi_s0", state_dbg, 4'd0);

        // sw interrupted by reset while waiting in MEM_WR.
        opcode = 6'h2B;
        nxt(1'b1, 1'b0);
        nxt(1'b1, 1'b0);
        chk("sw_s4", state_dbg, 4'd4);
        nxt(1'b0, 1'b0);
        chk("sw_s6", state_dbg, 4'd6);
        chk("sw_wr6", {mem_read, mem_write, i_or_d}, 3'b011);
        reset = 1'b0;
        #1;
        chk("sw_rst_memw", mem_write, 1'b0);
        chk("sw_rst_all", all_outs, 23'd0);
        nxt(1'b0, 1'b0);
        chk("sw_rst_hold", all_outs, 23'd0);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("sw_rel_s0", state_dbg, 4'd0);
        chk("sw_rel_regw", reg_write, 1'b0);

        // Opcode 0x3F
        opcode = 6'h3F;
        nxt(1'b1, 1'b0);
        chk("x3f_s1", state_dbg, 4'd1);
        nxt(1'b1, 1'b0);
`ifdef ULA_SEQ_INC_EN
        chk("inc_s12", state_dbg, 4'd12);
        chk("inc_b12", ula_b_sel, 3'b011);
        chk("inc_aluw", aluout_write, 1'b1);
        nxt(1'b1, 1'b0);
        chk("inc_s8", state_dbg, 4'd8);
        chk("inc_regw", reg_write, 1'b1);
        nxt(1'b1, 1'b0);
        chk("inc_s0", state_dbg, 4'd0);
`else
        chk("ill_s15", state_dbg, 4'd15);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_strobes", strobes, 6'd0);
        opcode = 6'h00;
        for (int i = 0; i < 11; i++) begin
            nxt(1'b1, 1'b1);
            chk("ill_hold_s", state_dbg, 4'd15);
            chk("ill_hold_flag", illegal, 1'b1);
            chk("ill_hold_strb", {strobes, ula_b_sel}, 9'd0);
        end
        reset = 1'b0;
        #1;
        chk("ill_rst_flag", illegal, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ill_rel_s0", state_dbg, 4'd0);
        chk("ill_rel_flag", illegal, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ula_seq_ctrl.md
# ula_seq_ctrl

Multicycle sequencing controller for the shared ALU datapath. Each instruction runs through fetch, decode, execute, memory and write-back states. In every state the block drives the ALU A-source select, the 3-bit B-source select (B / sign-extended imm / constant 4 / constant 1 / shifted imm) and the ALU operation. It also drives the PC, IR, register-file and memory write enables, and waits on a memory ready handshake. It sits between the instruction register and the datapath muxes, and is the only source of `ula_b_sel`.

## Interface
- No parameters. Opcode and funct fields are fixed at 6 bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory access completes this cycle
- ula_a_sel  out  1  0 = PC, 1 = register A
- ula_b_sel  out  3  000 B, 001 ext16_32, 010 const 4, 011 const 1, 100 ext16_32_left_shifted
- ula_op  out  3  000 pass A, 001 add, 010 sub, 011 and, 100 or, 111 slt
- pc_write, ir_write, aluout_write, reg_write, mem_read, mem_write  out  1 each  write/access strobes
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal  out  1  undecodable instruction seen; sticky
- state_dbg  out  4  current state encoding

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5, MEM_WR = 6, WB_R = 7, WB_I = 8, WB_MEM = 9, BRANCH = 10, JUMP = 11, INC = 12, ILLEGAL = 15.
- Outputs are combinational from the registered state plus `mem_ready` and `zero`.
- Every output not listed for a state is 0, and `ula_b_sel` defaults to 000.
- Per-state outputs and transitions:
  - FETCH:
    - Always: mem_read=1, i_or_d=0, a=0, b=010, op=add.
    - If mem_ready: ir_write=1, pc_write=1, pc_src=00, next state DECODE.
    - Otherwise stay in FETCH with no writes.
  - DECODE:
    - Outputs: a=0, b=100, op=add, aluout_write=1.
    - opcode 0x00 with funct in {0x20, 0x22, 0x24, 0x25, 0x2A} → EXEC_R.
    - 0x08 → EXEC_I; 0x23 or 0x2B → MEM_ADDR; 0x04 → BRANCH; 0x02 → JUMP.
    - Anything else → ILLEGAL.
  - EXEC_R: a=1, b=000, aluout_write=1, op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt) → WB_R.
  - EXEC_I: a=1, b=001, op=add, aluout_write=1 → WB_I.
  - INC: a=1, b=011, op=add, aluout_write=1 → WB_I.
  - MEM_ADDR: a=1, b=001, op=add, aluout_write=1 → MEM_RD if opcode is 0x23, MEM_WR if 0x2B.
  - MEM_RD: mem_read=1, i_or_d=1 → WB_MEM when mem_ready, otherwise hold.
  - MEM_WR: mem_write=1, i_or_d=1 → FETCH when mem_ready, otherwise hold.
  - WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
  - WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
  - WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
  - BRANCH: a=1, b=000, op=sub, pc_src=01; pc_write=zero → FETCH.
  - JUMP: pc_write=1, pc_src=10 → FETCH.
  - ILLEGAL: illegal=1, all strobes 0; stays until reset.
- `mem_read` and `mem_write` are never asserted together.

## Timing
- Reset asserted (asynchronous):
  - state → FETCH immediately.
  - All outputs forced to 0 while reset is low, including ula_b_sel=000, state_dbg=0 and illegal=0.
- First FETCH strobes occur in the first cycle after reset deasserts.
- Cycle counts with mem_ready tied high:
  - R-type 4, addi 4, lw 5, sw 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobes are single-cycle. pc_write and ir_write are never held across a wait.
- Reset mid-instruction abandons the instruction. No partial write-back strobe is issued.

## Configuration
- Macro: `ULA_SEQ_INC_EN`.
- Defined: DECODE sends opcode 0x3F to INC, so rt ← rs + 1 using ula_b_sel=011. Takes 4 cycles.
- Undefined: opcode 0x3F → ILLEGAL. Code 011 never appears on ula_b_sel.

## Test plan
- Reset low for 3 cycles, then release with mem_ready=1:
  - All outputs are 0 during reset.
  - Cycle 1 shows state_dbg=0, ula_b_sel=010, pc_write=1, ir_write=1.
- R-type add (opcode 0x00, funct 0x20) with mem_ready=1:
  - state_dbg sequence 0,1,2,7,0.
  - ula_b_sel sequence 010,100,000,000.
  - ula_op=001 in EXEC_R; reg_write=1 and reg_dst=1 in WB_R.
- lw (opcode 0x23) with mem_ready low for 2 cycles in MEM_RD:
  - 7 cycles total; state 5 is held for 3 cycles.
  - One reg_write with mem_to_reg=1 in state 9.
- beq (opcode 0x04):
  - zero=1 → pc_write=1 with pc_src=01 in state 10.
  - zero=0 → pc_write=0.
  - Both cases return to state 0.
- Opcode 0x3F:
  - Without ULA_SEQ_INC_EN: state 15, illegal=1 held for 10+ cycles, no strobes; cleared only by reset.
  - With ULA_SEQ_INC_EN: states 0,1,12,8, with ula_b_sel=011 in state 12.
- sw (opcode 0x2B) with reset asserted in MEM_WR while mem_ready=0:
  - mem_write drops the same cycle.
  - After release the bench sees state 0 and no reg_write.
